xor_parity_rx: RTL and testbench

XOR_PARITY_RX -- requirements
Module: xor_parity_rx

---
 rtl/xor_parity_rx.sv | 106 ++++++++++
 tb/tb_xor_parity_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_parity_rx.sv
// Serial receiver: start, 8 data bits LSB first, parity, stop (11 cycles per frame).
// Good frames go into a one-entry output buffer. Bad or dropped frames give a one-cycle error pulse.
module xor_parity_rx #(
  parameter logic PARITY_ODD = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DATA   = 3'd1;
  localparam logic [2:0] S_PARITY = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;

  logic [2:0] r_state;
  logic [2:0] r_cnt;
  logic [7:0] r_shift;
  logic       r_acc;
  logic [7:0] r_byte;
  logic       r_valid;
  logic       r_perr;
  logic       r_ferr;
  logic       r_ovr;

  logic w_stop;
  logic w_par_ok;
  logic w_good;
  logic w_load;
  logic w_pop;

  // The frame result is decided while the stop bit is on the line.
  // When the stop bit is 0, the frame error wins over a parity error.
  assign w_stop   = (r_state == S_STOP);
  assign w_par_ok = (r_acc == PARITY_ODD);
  assign w_good   = w_stop && in && w_par_ok;
  assign w_load   = w_good && (!r_valid || out_ready);
  assign w_pop    = r_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_acc   <= 1'b0;
      r_shift <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!in) begin
            r_state <= S_DATA;
            r_cnt   <= 3'd0;
            r_acc   <= 1'b0;
          end
        end
        S_DATA: begin
          r_shift <= {in, r_shift[7:1]};
          r_acc   <= r_acc ^ in;
          r_cnt   <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) r_state <= S_PARITY;
        end
        S_PARITY: begin
          r_acc   <= r_acc ^ in;
          r_state <= S_STOP;
        end
        // A stop bit of 1 returns to IDLE, so a start bit on the next cycle is accepted.
        S_STOP:  r_state <= in ? S_IDLE : S_WAIT;
        S_WAIT:  if (in) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte  <= 8'h00;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_stop && !in;
      r_perr <= w_stop && in && !w_par_ok;
      r_ovr  <= w_good && r_valid && !out_ready;
      if (w_load) begin
        r_byte  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_byte   = r_byte;
  assign out_valid  = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_xor_parity_rx.sv
// Bench for xor_parity_rx: a model predicts each frame's outcome and pushes it onto a scoreboard.
// Each scenario task pops the expected outcome and compares it after the stop bit.
module tb_xor_parity_rx;
  localparam logic ODD = 1'b1;

  logic       clk = 1'b0;
  logic       reset;
  logic       in;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  typedef struct packed {
    logic       v;
    logic [7:0] b;
    logic       pe;
    logic       fe;
    logic       ov;
  } res_t;

  res_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  int         n_pulse = 0;
  logic       m_valid;
  logic [7:0] m_byte;

  always #5 clk = ~clk;

  xor_parity_rx #(.PARITY_ODD(ODD)) dut (
    .clk(clk), .reset(reset), .in(in), .out_ready(out_ready),
    .out_byte(out_byte), .out_valid(out_valid),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  always @(negedge clk) if (parity_err || frame_err || overrun) n_pulse++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic res_t obs();
    res_t r;
    r = {out_valid, out_byte, parity_err, frame_err, overrun};
    return r;
  endfunction

  function automatic string fmt(res_t r);
    return $sformatf("v=%0b byte=%h pe=%0b fe=%0b ov=%0b", r.v, r.b, r.pe, r.fe, r.ov);
  endfunction

  function automatic logic par_of(logic [7:0] d);
    return (^d) ^ ODD;
  endfunction

  function automatic res_t idle_exp();
    res_t e;
    e = {m_valid, m_byte, 3'b000};
    return e;
  endfunction

  // The model updates the buffer state. Its result is the outcome expected on the cycle after the stop bit.
  function automatic res_t predict(logic [7:0] d, logic p, logic s, logic rdy_body, logic rdy_stop);
    res_t e;
    logic load;
    e = '0;
    load = 1'b0;
    if (m_valid && rdy_body) m_valid = 1'b0;
    if (!s) e.fe = 1'b1;
    else if (((^d) ^ p) != ODD) e.pe = 1'b1;
    else if (m_valid && !rdy_stop) e.ov = 1'b1;
    else load = 1'b1;
    if (load) begin
      m_byte  = d;
      m_valid = 1'b1;
    end else if (m_valid && rdy_stop) begin
      m_valid = 1'b0;
    end
    e.v = m_valid;
    e.b = m_byte;
    return e;
  endfunction

  // Drives one frame. On return, the outputs show the result on the cycle after the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input logic rdy_body, input logic rdy_stop);
    out_ready = rdy_body;
    in = 1'b0;
    tick;
    for (int i = 0; i < 8; i++) begin
      in = d[i];
      tick;
    end
    in = p;
    tick;
    in = s;
    out_ready = rdy_stop;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in = 1'b1; out_ready = 1'b0;
    tick; tick;
    m_valid = 1'b0; m_byte = 8'h00;
    total++;
    if (obs() !== res_t'(0)) begin
      bad++; $display("FAIL reset_state: got %s want all zero", fmt(obs()));
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_good_frame;
    res_t e;
    sb.push_back(predict(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0));
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("FAIL good_a5: got %s want %s", fmt(obs()), fmt(e)); end
    for (int i = 0; i < 3; i++) begin
      tick; total++;
      if (obs() !== idle_exp()) begin bad++; $display("FAIL hold_a5: got %s want %s", fmt(obs()), fmt(idle_exp())); end
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    m_valid = 1'b0;
    total++;
    if (obs() !== idle_exp()) begin bad++; $display("FAIL handshake: got %s want %s", fmt(obs()), fmt(idle_exp())); end
  endtask

  task automatic test_parity_err;
    res_t e;
    sb.push_back(predict(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0));
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("FAIL parity_err: got %s want %s", fmt(obs()), fmt(e)); end
    tick; total++;
    if (obs() !== idle_exp()) begin bad++; $display("FAIL parity_pulse_len: got %s want %s", fmt(obs()), fmt(idle_exp())); end
  endtask

  task automatic test_frame_err;
    res_t e;
    // A stop bit of 0 with a bad parity bit must still report only the frame error.
    sb.push_back(predict(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0));
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("FAIL frame_err: got %s want %s", fmt(obs()), fmt(e)); end
    in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick; total++;
      if (obs() !== idle_exp()) begin bad++; $display("FAIL wait_quiet: got %s want %s", fmt(obs()), fmt(idle_exp())); end
    end
    in = 1'b1;
    tick;
    sb.push_back(predict(8'h01, par_of(8'h01), 1'b1, 1'b0, 1'b0));
    send_frame(8'h01, par_of(8'h01), 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("FAIL after_wait_01: got %s want %s", fmt(obs()), fmt(e)); end
  endtask

  task automatic test_back_to_back(input logic rdy_second);
    res_t e;
    in = 1'b1; out_ready = 1'b1;
    tick;
    out_ready = 1'b0; m_valid = 1'b0;
    sb.push_back(predict(8'h12, par_of(8'h12), 1'b1, 1'b0, 1'b0));
    send_frame(8'h12, par_of(8'h12), 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("FAIL b2b_first: got %s want %s", fmt(obs()), fmt(e)); end
    sb.push_back(predict(8'h34, par_of(8'h34), 1'b1, 1'b0, rdy_second));
    send_frame(8'h34, par_of(8'h34), 1'b1, 1'b0, rdy_second);
    e = sb.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("FAIL b2b_second rdy=%0b: got %s want %s", rdy_second, fmt(obs()), fmt(e)); end
  endtask

  task automatic test_reset_midframe;
    res_t e;
    int   p0;
    out_ready = 1'b0;
    in = 1'b0; tick;
    in = 1'b1; tick;
    in = 1'b0; tick;
    in = 1'b0; tick;
    in = 1'b1; tick;
    p0 = n_pulse;
    reset = 1'b1; in = 1'b0;
    tick;
    reset = 1'b0;
    m_valid = 1'b0; m_byte = 8'h00;
    total++;
    if (obs() !== res_t'(0)) begin bad++; $display("FAIL midframe_reset: got %s want all zero", fmt(obs())); end
    // Odd parity for 0xFF needs a parity bit of 1.
    sb.push_back(predict(8'hFF, par_of(8'hFF), 1'b1, 1'b0, 1'b0));
    send_frame(8'hFF, par_of(8'hFF), 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); total++;
    if (obs() !== e) begin bad++; $display("FAIL after_reset_ff: got %s want %s", fmt(obs()), fmt(e)); end
    in = 1'b1; tick;
    total++;
    if (n_pulse != p0) begin bad++; $display("FAIL abandon_pulses: got %0d want 0", n_pulse - p0); end
  endtask

  task automatic test_random;
    res_t       e;
    logic [7:0] d;
    logic       p, s, rb, rs;
    for (int k = 0; k < 16; k++) begin
      d  = 8'($urandom_range(0, 255));
      p  = ($urandom_range(0, 3) == 0) ? ~par_of(d) : par_of(d);
      s  = ($urandom_range(0, 4) != 0);
      rb = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 1) == 1);
      sb.push_back(predict(d, p, s, rb, rs));
      send_frame(d, p, s, rb, rs);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin bad++; $display("FAIL rand_%0d d=%h: got %s want %s", k, d, fmt(obs()), fmt(e)); end
      in = 1'b1;
      tick; total++;
      if (obs() !== idle_exp()) begin bad++; $display("FAIL rand_idle_%0d: got %s want %s", k, fmt(obs()), fmt(idle_exp())); end
    end
  endtask

  initial begin
    reset = 1'b1; in = 1'b1; out_ready = 1'b0;
    m_valid = 1'b0; m_byte = 8'h00;
    test_reset;
    test_good_frame;
    test_parity_err;
    test_frame_err;
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_reset_midframe;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
